cbx_param_dbuf: RTL and testbench

- Parametrised connection block for a horizontal routing channel. It is the next generation of the fixed 13-track, 8-pin CBX.
- W-track bidirectional channel pass-through. N_IPIN binary-select input-pin muxes of MUX_SIZE inputs each.
- Configuration chain is double-buffered: a shadow shift register is loaded via ccff_head/ccff_tail and committed atomically to the active configuration.
- A bit-count check rejects short, long or mistimed bitstreams. Sits between the switch blocks on each row; chains into the fabric-wide configuration chain.

---
 rtl/cbx_param_dbuf_if.sv | 17 +
 rtl/cbx_param_dbuf.sv | 63 ++++++
 tb/tb_cbx_param_dbuf.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cbx_param_dbuf_if.sv
// cbx_param_dbuf_if: channel, pin and configuration-chain signals of one connection block
interface cbx_param_dbuf_if #(
  parameter int W = 13,
  parameter int N_IPIN = 8
);
  logic [W-1:0] chanx_left_in, chanx_right_in, chanx_left_out, chanx_right_out;
  logic [N_IPIN-1:0] ipin_out;
  logic ccff_head, ccff_en, cfg_commit, ccff_tail, cfg_active, cfg_err;
  modport master (
    output chanx_left_in, chanx_right_in, ccff_head, ccff_en, cfg_commit,
    input chanx_left_out, chanx_right_out, ipin_out, ccff_tail, cfg_active, cfg_err
  );
  modport slave (
    input chanx_left_in, chanx_right_in, ccff_head, ccff_en, cfg_commit,
    output chanx_left_out, chanx_right_out, ipin_out, ccff_tail, cfg_active, cfg_err
  );
endinterface

// File: rtl/cbx_param_dbuf.sv
// cbx_param_dbuf: parametrised connection block with a double-buffered, bit-counted config chain
module cbx_param_dbuf #(
  parameter int W = 13,
  parameter int N_IPIN = 8,
  parameter int MUX_SIZE = 4,
  parameter int TRACK_STEP = 3,
  parameter int TRACK_OFFSET = 1
) (
  input logic prog_clk,
  input logic pReset,
  cbx_param_dbuf_if.slave bus
);
  localparam int SEL_W = $clog2(MUX_SIZE);
  localparam int CHAIN_LEN = N_IPIN * SEL_W;
  localparam int CNT_W = $clog2(CHAIN_LEN + 2);
  localparam int PAD = 1 << SEL_W;
  logic [CHAIN_LEN-1:0] s, a;
  logic [CNT_W-1:0] cnt;
  logic act, err, accept;
  assign accept = bus.cfg_commit && !bus.ccff_en && cnt == CNT_W'(CHAIN_LEN);
  always_ff @(posedge prog_clk)
    if (!pReset) begin
      s <= '0;
      a <= '0;
      cnt <= '0;
      act <= 1'b0;
      err <= 1'b0;
    end else begin
      if (bus.ccff_en) begin
        s <= CHAIN_LEN'({s, bus.ccff_head});
        cnt <= cnt == CNT_W'(CHAIN_LEN + 1) ? cnt : cnt + 1'b1;
      end
      // a commit always restarts the count, even when it collides with a shift
      if (bus.cfg_commit) begin
        cnt <= '0;
        err <= !accept;
        if (accept) begin
          a <= s;
          act <= 1'b1;
        end
      end
    end
  assign bus.chanx_left_out = bus.chanx_right_in;
  assign bus.chanx_right_out = bus.chanx_left_in;
  assign bus.ccff_tail = s[CHAIN_LEN-1];
  assign bus.cfg_active = act;
  assign bus.cfg_err = err;
  for (genvar k = 0; k < N_IPIN; k++) begin : g_pin
    logic [PAD-1:0] m;
    logic [SEL_W-1:0] sel;
    assign sel = a[k*SEL_W +: SEL_W];
    // selects beyond MUX_SIZE land on zero-tied padding inputs
    for (genvar j = 0; j < PAD; j++) begin : g_in
      localparam int T = (k * TRACK_OFFSET + (j / 2) * TRACK_STEP + 3) % W;
      if (j < MUX_SIZE) begin : g_used
        assign m[j] = (j % 2) ? bus.chanx_right_in[T] : bus.chanx_left_in[T];
      end else begin : g_pad
        assign m[j] = 1'b0;
      end
    end
    assign bus.ipin_out[k] = act & m[sel];
  end
endmodule

// File: tb/tb_cbx_param_dbuf.sv
// tb_cbx_param_dbuf: scoreboarded random and directed stimulus against a queue-based reference model
module tb_cbx_param_dbuf;
  localparam int W = 13, NP = 8, MS = 4, TS = 3, TO = 1, SW = 2, CL = 16;
  localparam int CL6 = 24;
  logic clk = 1'b0, rst_n = 1'b0, rst6_n = 1'b0;
  always #5 clk = ~clk;
  cbx_param_dbuf_if #(.W(W), .N_IPIN(NP)) bus ();
  cbx_param_dbuf_if #(.W(W), .N_IPIN(NP)) bus6 ();
  cbx_param_dbuf #(.W(W), .N_IPIN(NP), .MUX_SIZE(MS), .TRACK_STEP(TS), .TRACK_OFFSET(TO))
    dut (.prog_clk(clk), .pReset(rst_n), .bus(bus));
  cbx_param_dbuf #(.W(W), .N_IPIN(NP), .MUX_SIZE(6), .TRACK_STEP(TS), .TRACK_OFFSET(TO))
    dut6 (.prog_clk(clk), .pReset(rst6_n), .bus(bus6));
  typedef struct {
    logic [W-1:0] lo, ro;
    logic tail, act, err;
    logic [NP-1:0] ipin;
  } exp_t;
  exp_t q[$];
  int npass = 0, nchk = 0;
  bit sh[$];
  int cnt_m = 0;
  bit act_m = 0, err_m = 0;
  int sel_m[NP];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  function automatic logic [NP-1:0] ref_ipin(input logic [W-1:0] l, input logic [W-1:0] r);
    logic [NP-1:0] v;
    v = '0;
    if (act_m)
      for (int k = 0; k < NP; k++)
        if (sel_m[k] < MS) begin
          int t;
          t = (k * TO + (sel_m[k] / 2) * TS + 3) % W;
          v[k] = (sel_m[k] % 2) ? r[t] : l[t];
        end
    return v;
  endfunction
  task automatic step(input bit r, input bit en, input bit hd, input bit cm,
                      input logic [W-1:0] l, input logic [W-1:0] rr);
    bit acc;
    exp_t e;
    @(negedge clk);
    rst_n = !r;
    bus.ccff_en = en;
    bus.ccff_head = hd;
    bus.cfg_commit = cm;
    bus.chanx_left_in = l;
    bus.chanx_right_in = rr;
    @(posedge clk);
    acc = cm && !en && cnt_m == CL;
    if (r) begin
      sh.delete();
      cnt_m = 0;
      act_m = 0;
      err_m = 0;
      foreach (sel_m[k]) sel_m[k] = 0;
    end else begin
      if (en) begin
        sh.push_back(hd);
        if (sh.size() > CL) void'(sh.pop_front());
        cnt_m++;
      end
      if (cm) begin
        cnt_m = 0;
        err_m = !acc;
        if (acc) begin
          act_m = 1;
          for (int k = 0; k < NP; k++) begin
            sel_m[k] = 0;
            for (int b = 0; b < SW; b++) if (sh[CL-1-(k*SW+b)]) sel_m[k] += 1 << b;
          end
        end
      end
    end
    e.lo = rr;
    e.ro = l;
    e.tail = sh.size() == CL ? sh[0] : 1'b0;
    e.act = act_m;
    e.err = err_m;
    e.ipin = ref_ipin(l, rr);
    q.push_back(e);
  endtask
  task automatic rstep(input bit r, input bit en, input bit hd, input bit cm);
    step(r, en, hd, cm, W'($urandom), W'($urandom));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rstep(0, 0, 0, 0);
  endtask
  task automatic shift_rand(input int n);
    for (int i = 0; i < n; i++) rstep(0, 1, 1'($urandom), 0);
  endtask
  task automatic shift_word(input logic [CL-1:0] v);
    for (int i = CL - 1; i >= 0; i--) rstep(0, 1, v[i], 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("chanx_left_out", 32'(bus.chanx_left_out), 32'(e.lo));
      chk("chanx_right_out", 32'(bus.chanx_right_out), 32'(e.ro));
      chk("ccff_tail", 32'(bus.ccff_tail), 32'(e.tail));
      chk("cfg_active", 32'(bus.cfg_active), 32'(e.act));
      chk("cfg_err", 32'(bus.cfg_err), 32'(e.err));
      chk("ipin_out", 32'(bus.ipin_out), 32'(e.ipin));
    end
  end
  function automatic logic [CL6-1:0] rep6(input int s);
    logic [CL6-1:0] v;
    for (int k = 0; k < NP; k++) v[k*3 +: 3] = 3'(s);
    return v;
  endfunction
  task automatic load6(input logic [CL6-1:0] v);
    for (int i = CL6 - 1; i >= 0; i--) begin
      @(negedge clk);
      rst6_n = 1'b1;
      bus6.ccff_en = 1'b1;
      bus6.ccff_head = v[i];
    end
    @(negedge clk);
    bus6.ccff_en = 1'b0;
    bus6.cfg_commit = 1'b1;
    @(negedge clk);
    bus6.cfg_commit = 1'b0;
  endtask
  task automatic probe6(input string n, input logic [W-1:0] l, input logic [W-1:0] r,
                        input logic [NP-1:0] e);
    bus6.chanx_left_in = l;
    bus6.chanx_right_in = r;
    #1;
    chk(n, 32'(bus6.ipin_out), 32'(e));
    chk({n, "_active"}, 32'(bus6.cfg_active), 32'd1);
    chk({n, "_err"}, 32'(bus6.cfg_err), 32'd0);
  endtask
  initial begin
    int opts[7] = '{14, 15, 16, 16, 16, 17, 18};
    {bus.ccff_en, bus.ccff_head, bus.cfg_commit} = '0;
    {bus6.ccff_en, bus6.ccff_head, bus6.cfg_commit} = '0;
    bus.chanx_left_in = '0;
    bus.chanx_right_in = '0;
    bus6.chanx_left_in = '0;
    bus6.chanx_right_in = '0;
    step(1, 0, 0, 0, 13'h1A5A, 13'h0F0F);
    step(1, 0, 0, 0, 13'h1A5A, 13'h0F0F);
    step(1, 1, 1, 1, 13'h1A5A, 13'h0F0F);
    shift_word(16'hAAAA);
    rstep(0, 0, 0, 1);
    step(0, 0, 0, 0, 13'(1 << 5), '0);
    step(0, 0, 0, 0, 13'(1 << 6), '0);
    idle(8);
    shift_rand(15);
    rstep(0, 0, 0, 1);
    idle(3);
    shift_rand(16);
    rstep(0, 0, 0, 1);
    idle(3);
    shift_rand(17);
    rstep(0, 0, 0, 1);
    idle(2);
    shift_rand(15);
    rstep(0, 1, 1'($urandom), 1);
    idle(3);
    shift_rand(8);
    rstep(1, 0, 0, 0);
    shift_rand(8);
    rstep(0, 0, 0, 1);
    idle(2);
    for (int r = 0; r < 60; r++) begin
      int n;
      n = opts[$urandom_range(0, 6)];
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        rstep($urandom_range(0, 79) == 0, 1, 1'($urandom), 0);
      end
      rstep(0, $urandom_range(0, 4) == 0, 1'($urandom), 1);
      idle($urandom_range(1, 4));
    end
    @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    @(negedge clk);
    rst6_n = 1'b0;
    @(negedge clk);
    load6(rep6(7));
    probe6("mux6_sel7", '1, '1, 8'h00);
    load6(rep6(5));
    probe6("mux6_sel5", '1, '1, 8'hFF);
    load6(rep6(6));
    probe6("mux6_sel6", '1, '1, 8'h00);
    load6(rep6(4));
    probe6("mux6_sel4_left", '1, '0, 8'hFF);
    probe6("mux6_sel4_right", '0, '1, 8'h00);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
